aabb_hit_reduce: RTL

Downstream reduction stage for the ray/AABB slab test. It consumes the 1-bit `greater` flags produced by the `greater_than` comparator instances, one comparison per cycle. It realigns each flag with the ray tag issued alongside the comparator operands, ANDs all flags belonging to one ray into a single hit bit, and buffers per-ray results in a small FIFO behind a valid/ready handshake. A credit counter throttles issue so that the non-stallable comparator pipeline can never overflow the FIFO.

---
 rtl/aabb_hit_reduce.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/aabb_hit_reduce.sv
// Reduction stage for the ray/AABB slab test: realigns comparator flags with their ray tags,
// ANDs each group into one hit bit, and queues per-ray results behind a credit-throttled FIFO.
module aabb_hit_reduce #(
    parameter int LAT        = 4,
    parameter int TAGW       = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [TAGW-1:0] in_tag,
    input  logic            in_last,
    input  logic            greater,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_hit,
    output logic [TAGW-1:0] out_tag,
    output logic            err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [LAT-1:0]  sl_vld_q, sl_vld_d;
    logic [LAT-1:0]  sl_last_q, sl_last_d;
    logic [TAGW-1:0] sl_tag_q [LAT];
    logic [TAGW-1:0] sl_tag_d [LAT];

    logic            acc_q, acc_d;
    logic            open_q, open_d;
    logic [TAGW-1:0] gtag_q, gtag_d;
    logic            err_q, err_d;

    logic [TAGW:0]   mem_q [FIFO_DEPTH];
    logic [TAGW:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cred_q, cred_d;

    logic            accept;
    logic            dv;
    logic            dlast;
    logic [TAGW-1:0] dtag;
    logic            hit;
    logic            push;
    logic            pop;

    // in_ready comes only from the credit register so it never depends on out_ready.
    assign in_ready  = rst & (cred_q < DEPTH_C);
    assign accept    = in_valid & in_ready;
    assign dv        = sl_vld_q[LAT-1];
    assign dlast     = sl_last_q[LAT-1];
    assign dtag      = sl_tag_q[LAT-1];
    assign hit       = acc_q & greater;
    assign push      = dv & dlast;
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid & out_ready;
    assign out_hit   = mem_q[rd_ptr_q][0];
    assign out_tag   = mem_q[rd_ptr_q][TAGW:1];
    assign err       = err_q;

    always_comb begin
        sl_vld_d     = sl_vld_q;
        sl_last_d    = sl_last_q;
        sl_tag_d     = sl_tag_q;
        for (int i = LAT - 1; i > 0; i--) begin
            sl_vld_d[i]  = sl_vld_q[i-1];
            sl_last_d[i] = sl_last_q[i-1];
            sl_tag_d[i]  = sl_tag_q[i-1];
        end
        sl_vld_d[0]  = accept;
        sl_last_d[0] = accept & in_last;
        sl_tag_d[0]  = accept ? in_tag : '0;
    end

    always_comb begin
        acc_d  = acc_q;
        open_d = open_q;
        gtag_d = gtag_q;
        err_d  = err_q;
        if (dv) begin
            if (!open_q) begin
                gtag_d = dtag;
            end else if (dtag != gtag_q) begin
                err_d = 1'b1;
            end
            if (dlast) begin
                acc_d  = 1'b1;
                open_d = 1'b0;
            end else begin
                acc_d  = hit;
                open_d = 1'b1;
            end
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        cred_d   = cred_q;
        if (push) begin
            mem_d[wr_ptr_q] = {dtag, hit};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        case ({accept & in_last, pop})
            2'b10:   cred_d = cred_q + CW'(1);
            2'b01:   cred_d = cred_q - CW'(1);
            default: cred_d = cred_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sl_vld_q  <= '0;
            sl_last_q <= '0;
            for (int i = 0; i < LAT; i++) sl_tag_q[i] <= '0;
            acc_q     <= 1'b1;
            open_q    <= 1'b0;
            gtag_q    <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            cred_q    <= '0;
        end else begin
            sl_vld_q  <= sl_vld_d;
            sl_last_q <= sl_last_d;
            sl_tag_q  <= sl_tag_d;
            acc_q     <= acc_d;
            open_q    <= open_d;
            gtag_q    <= gtag_d;
            err_q     <= err_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            cred_q    <= cred_d;
        end
    end

endmodule
